hazard_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core, directly downstream of the ID-stage instruction decoder.
- Consumes the decoder's per-instruction class flags, write address and register-write enable, plus the rs/rt fields.
- Keeps its own E/M/W shadow records of in-flight writers.
- Drives the stall/bubble control and every forwarding-mux select in D, E and M.

---
 rtl/hazard_unit_pkg.sv | 65 ++++++
 rtl/hazard_stage_rec.sv | 33 +++
 rtl/hazard_unit.sv | 123 ++++++++++++
 tb/tb_hazard_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard controller: forward codes, Tuse/Tnew constants,
// the in-flight writer record and the small matching helpers used by the top.
package hazard_unit_pkg;

    localparam int REG_W  = 5;
    localparam int TNEW_W = 2;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    localparam logic [1:0] TUSE_D = 2'd0;
    localparam logic [1:0] TUSE_E = 2'd1;
    localparam logic [1:0] TUSE_M = 2'd2;

    localparam logic [1:0] DEF_TNEW_CAL  = 2'd1;
    localparam logic [1:0] DEF_TNEW_LOAD = 2'd2;
    localparam logic [1:0] DEF_TNEW_LINK = 2'd0;

    typedef struct packed {
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  wa;
        logic              wr;
        logic [TNEW_W-1:0] tnew;
    } hz_rec_t;

    localparam int REC_W = $bits(hz_rec_t);

    // Writes to $0 are discarded by the register file, so they never match.
    function automatic logic rec_match(input hz_rec_t r, input logic [REG_W-1:0] a);
        return r.wr && (r.wa != '0) && (r.wa == a);
    endfunction

    function automatic logic stall_on(input hz_rec_t r, input logic [REG_W-1:0] a,
                                      input logic used, input logic [1:0] tuse);
        return used && rec_match(r, a) && (r.tnew > tuse);
    endfunction

    function automatic logic [1:0] fwd_d_code(input hz_rec_t e, input hz_rec_t m,
                                              input hz_rec_t w, input logic [REG_W-1:0] a);
        logic [1:0] code;
        code = FWD_RF;
        // A nearer writer that is not ready yet hides older ones; stall covers that case.
        if (rec_match(e, a)) begin
            if (e.tnew == '0) code = FWD_E;
        end else if (rec_match(m, a)) begin
            if (m.tnew == '0) code = FWD_M;
        end else if (rec_match(w, a)) begin
            code = FWD_W;
        end
        return code;
    endfunction

    function automatic logic [1:0] fwd_late_code(input hz_rec_t m, input hz_rec_t w,
                                                 input logic [REG_W-1:0] a);
        logic [1:0] code;
        code = FWD_RF;
        if (rec_match(m, a))      code = FWD_M;
        else if (rec_match(w, a)) code = FWD_W;
        return code;
    endfunction

endpackage

// File: rtl/hazard_stage_rec.sv
// One pipeline-stage shadow record: async clear, bubble load and saturating
// decrement of the cycles-until-ready counter.
module hazard_stage_rec
    import hazard_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_bubble,
    input  logic             i_decr,
    input  logic [REC_W-1:0] i_rec,
    output logic [REC_W-1:0] o_rec
);

    hz_rec_t          w_in;
    hz_rec_t          w_next;
    logic [REC_W-1:0] r_rec;

    assign w_in = hz_rec_t'(i_rec);

    always_comb begin
        w_next = w_in;
        if (i_decr && (w_in.tnew != '0)) w_next.tnew = w_in.tnew - 2'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      r_rec <= '0;
        else if (i_bubble) r_rec <= '0;
        else               r_rec <= w_next;
    end

    assign o_rec = r_rec;

endmodule

// File: rtl/hazard_unit.sv
// Stall and forwarding controller for the 5-stage MIPS core; tracks in-flight
// writers in E/M/W shadow records and compares them against ID-stage demand.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter logic [1:0] TNEW_CAL  = DEF_TNEW_CAL,
    parameter logic [1:0] TNEW_LOAD = DEF_TNEW_LOAD,
    parameter logic [1:0] TNEW_LINK = DEF_TNEW_LINK
)(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       d_cal_r,
    input  logic       d_cal_i,
    input  logic       d_branch,
    input  logic       d_load,
    input  logic       d_store,
    input  logic       d_jr,
    input  logic       d_link,
    input  logic       d_reg_write,
    input  logic [4:0] d_wa,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       fwd_m_rt
);

    hz_rec_t          w_d_rec;
    hz_rec_t          w_e;
    hz_rec_t          w_m;
    hz_rec_t          w_w;
    logic [REC_W-1:0] w_e_bits;
    logic [REC_W-1:0] w_m_bits;
    logic [REC_W-1:0] w_w_bits;
    logic             w_rs_used;
    logic             w_rt_used;
    logic [1:0]       w_tuse_rs;
    logic [1:0]       w_tuse_rt;
    logic             w_unused;

    assign w_e = hz_rec_t'(w_e_bits);
    assign w_m = hz_rec_t'(w_m_bits);
    assign w_w = hz_rec_t'(w_w_bits);

    always_comb begin
        w_d_rec    = '0;
        w_d_rec.rs = d_rs;
        w_d_rec.rt = d_rt;
        w_d_rec.wa = d_wa;
        w_d_rec.wr = d_reg_write;
        if (d_load)                w_d_rec.tnew = TNEW_LOAD;
        else if (d_cal_r || d_cal_i) w_d_rec.tnew = TNEW_CAL;
        else if (d_link)           w_d_rec.tnew = TNEW_LINK;
    end

    // Operand demand: when each source is first needed, counted from D.
    always_comb begin
        w_rs_used = 1'b0;
        w_tuse_rs = TUSE_D;
        w_rt_used = 1'b0;
        w_tuse_rt = TUSE_D;
        if (d_branch || d_jr) begin
            w_rs_used = 1'b1;
        end else if (d_cal_r || d_cal_i || d_load || d_store) begin
            w_rs_used = 1'b1;
            w_tuse_rs = TUSE_E;
        end
        if (d_branch) begin
            w_rt_used = 1'b1;
        end else if (d_cal_r) begin
            w_rt_used = 1'b1;
            w_tuse_rt = TUSE_E;
        end else if (d_store) begin
            w_rt_used = 1'b1;
            w_tuse_rt = TUSE_M;
        end
    end

    assign stall = stall_on(w_e, d_rs, w_rs_used, w_tuse_rs) ||
                   stall_on(w_m, d_rs, w_rs_used, w_tuse_rs) ||
                   stall_on(w_e, d_rt, w_rt_used, w_tuse_rt) ||
                   stall_on(w_m, d_rt, w_rt_used, w_tuse_rt);

    assign fwd_d_rs = fwd_d_code(w_e, w_m, w_w, d_rs);
    assign fwd_d_rt = fwd_d_code(w_e, w_m, w_w, d_rt);
    assign fwd_e_rs = fwd_late_code(w_m, w_w, w_e.rs);
    assign fwd_e_rt = fwd_late_code(w_m, w_w, w_e.rt);
    assign fwd_m_rt = rec_match(w_w, w_m.rt);

    assign w_unused = ^{w_m.rs, w_w.rs, w_w.rt, w_w.tnew};

    hazard_stage_rec u_rec_e (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_bubble (stall),
        .i_decr   (1'b0),
        .i_rec    (REC_W'(w_d_rec)),
        .o_rec    (w_e_bits)
    );

    hazard_stage_rec u_rec_m (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_bubble (1'b0),
        .i_decr   (1'b1),
        .i_rec    (w_e_bits),
        .o_rec    (w_m_bits)
    );

    // Decrementing again on the way into W keeps W.tnew at zero even for loads.
    hazard_stage_rec u_rec_w (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_bubble (1'b0),
        .i_decr   (1'b1),
        .i_rec    (w_m_bits),
        .o_rec    (w_w_bits)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed pipeline scenarios plus a
// randomized instruction stream compared against an age-based pipeline model.
module tb_hazard_unit;

    localparam logic [6:0] C_NOP = 7'b0000000;
    localparam logic [6:0] C_CALR = 7'b1000000;
    localparam logic [6:0] C_CALI = 7'b0100000;
    localparam logic [6:0] C_BR  = 7'b0010000;
    localparam logic [6:0] C_LD  = 7'b0001000;
    localparam logic [6:0] C_ST  = 7'b0000100;
    localparam logic [6:0] C_JR  = 7'b0000010;
    localparam logic [6:0] C_LNK = 7'b0000001;

    logic       clk;
    logic       reset_n;
    logic [6:0] d_cls;
    logic       d_reg_write;
    logic [4:0] d_wa, d_rs, d_rt;
    logic       stall, fwd_m_rt;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
    logic [9:0] w_obs;

    int nvec = 0;
    int nerr = 0;

    // Model record: an instruction plus the age-0 readiness delay; stage index = age.
    typedef struct {
        logic [4:0] rs, rt, wa;
        logic       wr;
        int         tnew0;
    } mrec_t;
    mrec_t pipe[3];

    hazard_unit dut (
        .clk(clk), .reset_n(reset_n),
        .d_cal_r(d_cls[6]), .d_cal_i(d_cls[5]), .d_branch(d_cls[4]), .d_load(d_cls[3]),
        .d_store(d_cls[2]), .d_jr(d_cls[1]), .d_link(d_cls[0]),
        .d_reg_write(d_reg_write), .d_wa(d_wa), .d_rs(d_rs), .d_rt(d_rt),
        .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt)
    );

    assign w_obs = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [9:0] pk(input logic s, input logic [1:0] drs, input logic [1:0] drt,
                                      input logic [1:0] ers, input logic [1:0] ert, input logic mrt);
        return {s, drs, drt, ers, ert, mrt};
    endfunction

    function automatic int rem(input int s);
        int r;
        r = pipe[s].tnew0 - s;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic logic hits(input int s, input logic [4:0] a);
        return pipe[s].wr && (pipe[s].wa != 5'd0) && (pipe[s].wa == a);
    endfunction

    function automatic logic [1:0] dsel(input logic [4:0] a);
        for (int s = 0; s < 3; s++)
            if (hits(s, a)) return (rem(s) == 0) ? 2'(s + 1) : 2'd0;
        return 2'd0;
    endfunction

    function automatic logic [1:0] late(input logic [4:0] a);
        for (int s = 1; s < 3; s++)
            if (hits(s, a)) return 2'(s + 1);
        return 2'd0;
    endfunction

    function automatic logic [9:0] model_out();
        int  trs, trt;
        logic st;
        trs = -1;
        trt = -1;
        if (d_cls[4] || d_cls[1]) trs = 0;
        else if (d_cls[6] || d_cls[5] || d_cls[3] || d_cls[2]) trs = 1;
        if (d_cls[4]) trt = 0;
        else if (d_cls[6]) trt = 1;
        else if (d_cls[2]) trt = 2;
        st = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (trs >= 0 && hits(s, d_rs) && rem(s) > trs) st = 1'b1;
            if (trt >= 0 && hits(s, d_rt) && rem(s) > trt) st = 1'b1;
        end
        return pk(st, dsel(d_rs), dsel(d_rt), late(pipe[0].rs), late(pipe[0].rt), hits(2, pipe[1].rt));
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 3; s++) pipe[s] = '{5'd0, 5'd0, 5'd0, 1'b0, 0};
    endtask

    task automatic apply(input logic [6:0] cls, input logic wr, input logic [4:0] wa,
                         input logic [4:0] rs, input logic [4:0] rt);
        d_cls = cls; d_reg_write = wr; d_wa = wa; d_rs = rs; d_rt = rt;
    endtask

    task automatic tick();
        logic [9:0] e;
        e = model_out();
        @(posedge clk);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (e[9]) pipe[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 0};
        else pipe[0] = '{d_rs, d_rt, d_wa, d_reg_write,
                         d_cls[3] ? 2 : ((d_cls[6] || d_cls[5]) ? 1 : 0)};
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        apply(C_NOP, 0, 0, 0, 0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        apply(C_NOP, 0, 0, 0, 0);
        model_clear();
        #12;
        nvec++; if (w_obs !== 10'd0) begin nerr++; $display("FAIL reset_held: got %b exp %b", w_obs, 10'd0); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        nvec++; if (w_obs !== 10'd0) begin nerr++; $display("FAIL reset_release: got %b exp %b", w_obs, 10'd0); end
    endtask

    task automatic test_load_use();
        logic [9:0] e;
        do_reset();
        apply(C_LD, 1, 8, 0, 8); #1;
        tick();
        apply(C_CALR, 1, 9, 8, 10); #1;
        e = pk(1, 0, 0, 0, 0, 0);
        nvec++; if (w_obs !== e) begin nerr++; $display("FAIL load_use_stall: got %b exp %b", w_obs, e); end
        tick(); #1;
        e = pk(0, 0, 0, 0, 0, 0);
        nvec++; if (w_obs !== e) begin nerr++; $display("FAIL load_use_release: got %b exp %b", w_obs, e); end
        tick();
        apply(C_NOP, 0, 0, 0, 0); #1;
        e = pk(0, 0, 0, 3, 0, 0);
        nvec++; if (w_obs !== e) begin nerr++; $display("FAIL load_use_fwd_e: got %b exp %b", w_obs, e); end
    endtask

    task automatic test_branch_alu();
        logic [9:0] e;
        do_reset();
        apply(C_CALI, 1, 5, 0, 5); #1;
        tick();
        apply(C_BR, 0, 0, 5, 0); #1;
        e = pk(1, 0, 0, 0, 0, 0);
        nvec++; if (w_obs !== e) begin nerr++; $display("FAIL br_alu_stall: got %b exp %b", w_obs, e); end
        tick(); #1;
        e = pk(0, 2, 0, 0, 0, 0);
        nvec++; if (w_obs !== e) begin nerr++; $display("FAIL br_alu_fwd_m: got %b exp %b", w_obs, e); end
    endtask

    task automatic test_branch_load();
        logic [9:0] e;
        do_reset();
        apply(C_LD, 1, 5, 0, 5); #1;
        tick();
        apply(C_BR, 0, 0, 5, 6); #1;
        e = pk(1, 0, 0, 0, 0, 0);
        nvec++; if (w_obs !== e) begin nerr++; $display("FAIL br_ld_stall1: got %b exp %b", w_obs, e); end
        tick(); #1;
        nvec++; if (w_obs !== e) begin nerr++; $display("FAIL br_ld_stall2: got %b exp %b", w_obs, e); end
        tick(); #1;
        e = pk(0, 3, 0, 0, 0, 0);
        nvec++; if (w_obs !== e) begin nerr++; $display("FAIL br_ld_fwd_w: got %b exp %b", w_obs, e); end
    endtask

    task automatic test_link();
        logic [9:0] e;
        do_reset();
        apply(C_LNK, 1, 31, 0, 0); #1;
        tick();
        apply(C_JR, 0, 0, 31, 0); #1;
        e = pk(0, 1, 0, 0, 0, 0);
        nvec++; if (w_obs !== e) begin nerr++; $display("FAIL link_fwd_e: got %b exp %b", w_obs, e); end
    endtask

    task automatic test_store();
        logic [9:0] e;
        do_reset();
        apply(C_LD, 1, 4, 0, 4); #1;
        tick();
        apply(C_ST, 0, 0, 2, 4); #1;
        e = pk(0, 0, 0, 0, 0, 0);
        nvec++; if (w_obs !== e) begin nerr++; $display("FAIL store_nostall: got %b exp %b", w_obs, e); end
        tick();
        apply(C_NOP, 0, 0, 0, 0); #1;
        e = pk(0, 0, 0, 0, 2, 0);
        nvec++; if (w_obs !== e) begin nerr++; $display("FAIL store_fwd_e_rt: got %b exp %b", w_obs, e); end
        tick(); #1;
        e = pk(0, 0, 0, 0, 0, 1);
        nvec++; if (w_obs !== e) begin nerr++; $display("FAIL store_fwd_m_rt: got %b exp %b", w_obs, e); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        apply(C_CALR, 1, 0, 1, 2); #1;
        tick();
        apply(C_BR, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            nvec++; if (w_obs !== 10'd0) begin nerr++; $display("FAIL zero_reg_%0d: got %b exp %b", i, w_obs, 10'd0); end
            tick();
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [9:0] e;
        do_reset();
        apply(C_LD, 1, 8, 0, 8); #1;
        tick();
        apply(C_CALR, 1, 9, 8, 10); #1;
        e = pk(1, 0, 0, 0, 0, 0);
        nvec++; if (w_obs !== e) begin nerr++; $display("FAIL rst_mid_pre: got %b exp %b", w_obs, e); end
        #1 reset_n = 1'b0;
        model_clear();
        #1;
        nvec++; if (w_obs !== 10'd0) begin nerr++; $display("FAIL rst_mid_async: got %b exp %b", w_obs, 10'd0); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        nvec++; if (w_obs !== 10'd0) begin nerr++; $display("FAIL rst_mid_after: got %b exp %b", w_obs, 10'd0); end
    endtask

    function automatic logic [4:0] rreg();
        logic [4:0] tbl [4];
        tbl = '{5'd0, 5'd1, 5'd2, 5'd31};
        return tbl[$urandom_range(0, 3)];
    endfunction

    task automatic test_random();
        logic [6:0] tbl [8];
        logic [9:0] e;
        logic       held;
        int         k;
        tbl = '{C_CALR, C_CALI, C_BR, C_LD, C_ST, C_JR, C_LNK, C_NOP};
        do_reset();
        held = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!held) begin
                k = $urandom_range(0, 7);
                apply(tbl[k], (k == 0 || k == 1 || k == 3 || k == 6), (k == 6) ? 5'd31 : rreg(),
                      rreg(), rreg());
            end
            #1;
            e = model_out();
            nvec++;
            if (w_obs !== e) begin
                nerr++;
                $display("FAIL random_%0d: got %b exp %b", i, w_obs, e);
            end
            held = e[9];
            tick();
        end
    endtask

    initial begin
        apply(C_NOP, 0, 0, 0, 0);
        reset_n = 1'b0;
        model_clear();
        test_reset();
        test_load_use();
        test_branch_alu();
        test_branch_load();
        test_link();
        test_store();
        test_zero_reg();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
